// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM slave: FSM states, default device address
// and the bus levels that mean ACK / NACK during the ninth clock of a byte.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_WADDR,
        ST_WADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_MACK
    } state_t;

    localparam logic [6:0] DEFAULT_ADDRESS = 7'b1010_000;

    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input followed by a history
// register, giving the synchronized level plus single-cycle rise/fall strobes.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Resetting to 1 matches an idle (pulled-up) bus, so no edge is seen at reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 24xx-style serial EEPROM: address match, word-address load,
// sequential writes and reads on an internal byte array, open-drain SDA output.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS    = DEFAULT_ADDRESS,
    parameter int         MEM_BYTES  = 1024,
    parameter int         ADDR_BYTES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic sda_oen
);

    localparam int PTR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic scl_lvl, scl_rise_raw, scl_fall_raw;
    logic sda_lvl, sda_rise, sda_fall;

    logic start_cond, stop_cond;
    logic scl_rise, scl_fall;

    state_t state, state_next;

    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [7:0]       byte_in;
    logic [7:0]       rd_shift;
    logic [15:0]      waddr;
    logic [1:0]       addr_cnt;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic             oen_q;
    logic             last_bit;
    logic             in_ack;

    logic oen_d;
    logic mem_we;
    logic ptr_inc;
    logic ptr_load;
    logic rd_load;
    logic addr_push;

    logic [7:0] mem [MEM_BYTES];

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise_raw),
        .fall  (scl_fall_raw)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Bus conditions outrank bit handling, so SCL edges are masked in a START/STOP cycle.
    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign scl_rise   = scl_rise_raw & ~start_cond & ~stop_cond;
    assign scl_fall   = scl_fall_raw & ~start_cond & ~stop_cond;

    assign byte_in  = {shift[6:0], sda_lvl};
    assign last_bit = (bit_cnt == 4'd7);
    assign in_ack   = (state inside {ST_DEV_ACK, ST_WADDR_ACK, ST_WDATA_ACK, ST_RD_MACK});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_cond) begin
            state_next = ST_DEV;
        end else if (stop_cond) begin
            state_next = ST_IDLE;
        end else if (scl_rise) begin
            case (state)
                ST_IDLE:      state_next = ST_IDLE;
                ST_DEV:       if (last_bit) state_next = (byte_in[7:1] == ADDRESS) ? ST_DEV_ACK : ST_IDLE;
                ST_DEV_ACK:   state_next = rw ? ST_RDATA : ST_WADDR;
                ST_WADDR:     if (last_bit) state_next = ST_WADDR_ACK;
                ST_WADDR_ACK: state_next = (addr_cnt == 2'(ADDR_BYTES)) ? ST_WDATA : ST_WADDR;
                ST_WDATA:     if (last_bit) state_next = ST_WDATA_ACK;
                ST_WDATA_ACK: state_next = ST_WDATA;
                ST_RDATA:     if (last_bit) state_next = ST_RD_MACK;
                ST_RD_MACK:   state_next = (sda_lvl == NACK_LEVEL) ? ST_IDLE : ST_RDATA;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // SDA only changes on SCL fall; ACK states pull low for exactly the ninth clock.
    always_comb begin
        oen_d     = oen_q;
        mem_we    = 1'b0;
        ptr_inc   = 1'b0;
        ptr_load  = 1'b0;
        rd_load   = 1'b0;
        addr_push = 1'b0;
        if (start_cond || stop_cond) begin
            oen_d = 1'b1;
        end else begin
            case (state)
                ST_IDLE: oen_d = 1'b1;
                ST_DEV: begin
                    if (scl_fall) oen_d = 1'b1;
                end
                ST_DEV_ACK: begin
                    if (scl_fall) oen_d = ACK_LEVEL;
                    if (scl_rise) rd_load = rw;
                end
                ST_WADDR: begin
                    if (scl_fall) oen_d = 1'b1;
                    if (scl_rise && last_bit) addr_push = 1'b1;
                end
                ST_WADDR_ACK: begin
                    if (scl_fall) oen_d = ACK_LEVEL;
                    if (scl_rise && addr_cnt == 2'(ADDR_BYTES)) ptr_load = 1'b1;
                end
                ST_WDATA: begin
                    if (scl_fall) oen_d = 1'b1;
                    if (scl_rise && last_bit) begin
                        mem_we  = 1'b1;
                        ptr_inc = 1'b1;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) oen_d = ACK_LEVEL;
                end
                ST_RDATA: begin
                    if (scl_fall) oen_d = rd_shift[7];
                    if (scl_rise && last_bit) ptr_inc = 1'b1;
                end
                ST_RD_MACK: begin
                    if (scl_fall) oen_d = 1'b1;
                    if (scl_rise && sda_lvl == ACK_LEVEL) rd_load = 1'b1;
                end
                default: oen_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            shift    <= '0;
            rd_shift <= '0;
            waddr    <= '0;
            addr_cnt <= '0;
            rw       <= 1'b0;
            ptr      <= '0;
            oen_q    <= 1'b1;
        end else begin
            oen_q <= oen_d;
            if (start_cond) begin
                bit_cnt  <= '0;
                addr_cnt <= '0;
            end else if (stop_cond) begin
                bit_cnt <= '0;
            end else if (scl_rise && state != ST_IDLE) begin
                shift   <= byte_in;
                bit_cnt <= in_ack ? 4'd0 : bit_cnt + 4'd1;
                if (state == ST_DEV && last_bit) rw <= sda_lvl;
                if (state == ST_RDATA) rd_shift <= {rd_shift[6:0], 1'b0};
            end
            if (addr_push) begin
                waddr    <= {waddr[7:0], byte_in};
                addr_cnt <= addr_cnt + 2'd1;
            end
            if (rd_load) rd_shift <= mem[ptr];
            // Pointer wraps at the array depth so sequential transfers roll over to 0.
            if (ptr_load) begin
                ptr <= PTR_W'(32'(waddr) % MEM_BYTES);
            end else if (ptr_inc) begin
                ptr <= (ptr == PTR_W'(MEM_BYTES - 1)) ? '0 : ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= byte_in;
    end

    assign sda_o   = 1'b0;
    assign sda_oen = oen_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master driving the EEPROM slave through a wired-AND SDA line,
// with a byte-array reference model of the EEPROM contents.
module tb_i2c_eeprom_slave;

    localparam int Q     = 6;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_o;
    logic sda_oen;
    logic sda_bus;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_mem [DEPTH];
    bit         written   [DEPTH];

    assign sda_bus = m_sda & (sda_oen | sda_o);

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .ADDRESS    (7'h50),
        .MEM_BYTES  (DEPTH),
        .ADDR_BYTES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (m_scl),
        .sda_i   (sda_bus),
        .sda_o   (sda_o),
        .sda_oen (sda_oen)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic scl, input logic sda, input int n);
        m_scl = scl;
        m_sda = sda;
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        applyStimulus(m_scl, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b0, 1'b0, Q);
    endtask

    task automatic i2c_stop();
        applyStimulus(1'b0, 1'b0, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b1, 1'b1, Q);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        applyStimulus(1'b0, b, Q);
        applyStimulus(1'b1, b, Q);
        s = sda_bus;
        applyStimulus(1'b1, b, Q);
        applyStimulus(1'b0, b, Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    task automatic addr_phase(input logic [15:0] a, input string tag);
        logic ack;
        send_byte(8'hA0, ack);
        checkOutput({tag, "_dev_ack"}, 16'(ack), 16'h0);
        send_byte(a[15:8], ack);
        checkOutput({tag, "_ahi_ack"}, 16'(ack), 16'h0);
        send_byte(a[7:0], ack);
        checkOutput({tag, "_alo_ack"}, 16'(ack), 16'h0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] data[$], input string tag);
        logic ack;
        int   p;
        i2c_start();
        addr_phase(a, tag);
        p = int'(a) % DEPTH;
        foreach (data[k]) begin
            send_byte(data[k], ack);
            checkOutput($sformatf("%s_d%0d_ack", tag, k), 16'(ack), 16'h0);
            model_mem[p] = data[k];
            written[p]   = 1'b1;
            p = (p + 1) % DEPTH;
        end
        i2c_stop();
        checkOutput({tag, "_oen_after_stop"}, 16'(sda_oen), 16'h1);
    endtask

    task automatic do_read(input logic [15:0] a, input int n, output logic [7:0] rq[$], input string tag);
        logic       ack;
        logic [7:0] d;
        rq = {};
        i2c_start();
        addr_phase(a, tag);
        i2c_start();
        send_byte(8'hA1, ack);
        checkOutput({tag, "_rdev_ack"}, 16'(ack), 16'h0);
        for (int k = 0; k < n; k++) begin
            recv_byte((k == n - 1) ? 1'b1 : 1'b0, d);
            rq.push_back(d);
        end
        i2c_stop();
        checkOutput({tag, "_oen_after_stop"}, 16'(sda_oen), 16'h1);
    endtask

    task automatic check_model(input logic [15:0] a, input logic [7:0] rq[$], input string tag);
        int p;
        p = int'(a) % DEPTH;
        foreach (rq[k]) begin
            if (written[p]) checkOutput($sformatf("%s_b%0d", tag, k), 16'(rq[k]), 16'(model_mem[p]));
            p = (p + 1) % DEPTH;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]  wq[$];
        logic [7:0]  rq[$];
        logic [15:0] addrs[$];
        int          lens[$];
        logic        ack;
        logic        s;
        logic [6:0]  dev;

        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 5);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("reset_oen", 16'(sda_oen), 16'h1);
        checkOutput("reset_sda_o", 16'(sda_o), 16'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 10);
            checkOutput($sformatf("idle_oen%0d", i), 16'(sda_oen), 16'h1);
        end

        wq = {8'hDE, 8'hAD};
        do_write(16'h0010, wq, "wr_basic");

        do_read(16'h0010, 2, rq, "rd_random");
        checkOutput("rd_random_b0", 16'(rq[0]), 16'h00DE);
        checkOutput("rd_random_b1", 16'(rq[1]), 16'h00AD);

        i2c_start();
        send_byte(8'hA2, ack);
        checkOutput("mismatch_dev_nack", 16'(ack), 16'h1);
        send_byte(8'h00, ack);
        checkOutput("mismatch_b1_nack", 16'(ack), 16'h1);
        send_byte(8'h10, ack);
        checkOutput("mismatch_b2_nack", 16'(ack), 16'h1);
        send_byte(8'h55, ack);
        checkOutput("mismatch_b3_nack", 16'(ack), 16'h1);
        i2c_stop();
        do_read(16'h0010, 2, rq, "rd_after_mismatch");
        checkOutput("rd_after_mismatch_b0", 16'(rq[0]), 16'h00DE);
        checkOutput("rd_after_mismatch_b1", 16'(rq[1]), 16'h00AD);

        wq = {8'h11, 8'h22};
        do_write(16'h03FF, wq, "wr_wrap");
        do_read(16'h03FF, 2, rq, "rd_wrap");
        checkOutput("rd_wrap_b0", 16'(rq[0]), 16'h0011);
        checkOutput("rd_wrap_b1", 16'(rq[1]), 16'h0022);
        do_read(16'h0000, 1, rq, "rd_zero");
        checkOutput("rd_zero_b0", 16'(rq[0]), 16'h0022);

        wq = {8'h5A};
        do_write(16'h0020, wq, "wr_pre");
        i2c_start();
        addr_phase(16'h0020, "partial");
        bit_xfer(1'b1, s);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        bit_xfer(1'b0, s);
        i2c_stop();
        checkOutput("partial_oen", 16'(sda_oen), 16'h1);
        do_read(16'h0020, 1, rq, "rd_partial");
        checkOutput("rd_partial_b0", 16'(rq[0]), 16'h005A);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            int          len;
            a   = 16'($urandom_range(0, 16'hFFFF));
            len = $urandom_range(1, 4);
            wq  = {};
            for (int k = 0; k < len; k++) wq.push_back(8'($urandom_range(0, 255)));
            do_write(a, wq, $sformatf("rnd_wr%0d", i));
            addrs.push_back(a);
            lens.push_back(len);
        end

        dev = 7'($urandom_range(0, 127));
        if (dev == 7'h50) dev = 7'h51;
        i2c_start();
        send_byte({dev, 1'($urandom_range(0, 1))}, ack);
        checkOutput("rnd_mismatch_nack", 16'(ack), 16'h1);
        i2c_stop();

        foreach (addrs[i]) begin
            do_read(addrs[i], lens[i], rq, $sformatf("rnd_rd%0d", i));
            check_model(addrs[i], rq, $sformatf("rnd_rd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
